dm_sb_arbiter: RTL

Round-robin arbiter that shares the debug module's single system-bus master port between `NrReq` requesters (the SBA engine plus additional bus clients, e.g. a second hart-side or trace master). It sits between the requesters' req/gnt/r_valid interfaces and the system bus. It allows exactly one transaction in flight and routes each response back to the requester that issued it. A configurable response timeout converts a hung bus into an error response.

---
 rtl/dm_sb_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dm_sb_arbiter.sv
// Round-robin arbiter sharing the debug module's system-bus master port; one transaction in flight.
// Latency: 0 cycles request-to-master_req, grant and response passed through combinationally.
// Backpressure: requesters hold req/payload until gnt; a hung bus is turned into an error response.
module dm_sb_arbiter #(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned NrReq         = 2,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               dmactive_i,
  input  logic [NrReq-1:0]                   req_i,
  input  logic [NrReq-1:0][BusWidth-1:0]     add_i,
  input  logic [NrReq-1:0]                   we_i,
  input  logic [NrReq-1:0][BusWidth-1:0]     wdata_i,
  input  logic [NrReq-1:0][BusWidth/8-1:0]   be_i,
  output logic [NrReq-1:0]                   gnt_o,
  output logic [NrReq-1:0]                   r_valid_o,
  output logic [NrReq-1:0]                   r_err_o,
  output logic [BusWidth-1:0]                r_rdata_o,
  output logic                               master_req_o,
  output logic [BusWidth-1:0]                master_add_o,
  output logic                               master_we_o,
  output logic [BusWidth-1:0]                master_wdata_o,
  output logic [BusWidth/8-1:0]              master_be_o,
  input  logic                               master_gnt_i,
  input  logic                               master_r_valid_i,
  input  logic [BusWidth-1:0]                master_r_rdata_i,
  output logic                               busy_o
);

  localparam int unsigned RrW   = $clog2(NrReq);
  localparam int unsigned CntW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam int unsigned TLast = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;

  typedef enum logic [1:0] {Idle, ReqHold, WaitResp} state_e;

  state_e          state_q, state_d;
  logic [RrW-1:0]  owner_q, owner_d;
  logic [RrW-1:0]  rr_q, rr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RrW-1:0]  winner;
  logic [RrW-1:0]  sel;
  logic            any_req;
  int unsigned     idx;

  // Next round-robin pointer; explicit wrap so non-power-of-2 NrReq works.
  function automatic logic [RrW-1:0] rr_inc(input logic [RrW-1:0] v);
    if (int'(v) == int'(NrReq) - 1) return '0;
    else return v + RrW'(1);
  endfunction

  // Pick the first asserted request scanning upward from rr_q, wrapping.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NrReq; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NrReq) idx = idx - NrReq;
      if (!any_req && req_i[RrW'(idx)]) begin
        any_req = 1'b1;
        winner  = RrW'(idx);
      end
    end
  end

  // State, owner, priority pointer and timeout counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic plus grant/response routing back to the owning requester.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    sel          = owner_q;
    master_req_o = 1'b0;
    gnt_o        = '0;
    r_valid_o    = '0;
    r_err_o      = '0;
    r_rdata_o    = master_r_rdata_i;

    unique case (state_q)
      Idle: begin
        if (any_req) begin
          master_req_o = 1'b1;
          sel          = winner;
          owner_d      = winner;
          if (master_gnt_i) begin
            gnt_o[winner] = 1'b1;
            rr_d          = rr_inc(winner);
            cnt_d         = '0;
            state_d       = WaitResp;
          end else begin
            state_d = ReqHold;
          end
        end
      end
      ReqHold: begin
        // Payload stays pinned to the owner until the bus accepts it.
        master_req_o = 1'b1;
        if (master_gnt_i) begin
          gnt_o[owner_q] = 1'b1;
          rr_d           = rr_inc(owner_q);
          cnt_d          = '0;
          state_d        = WaitResp;
        end
      end
      WaitResp: begin
        if (master_r_valid_i) begin
          r_valid_o[owner_q] = 1'b1;
          state_d            = Idle;
        end else if (TimeoutCycles > 0 && cnt_q == CntW'(TLast)) begin
          r_valid_o[owner_q] = 1'b1;
          r_err_o[owner_q]   = 1'b1;
          r_rdata_o          = '0;
          state_d            = Idle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = Idle;
    endcase

    // Handshake outputs are quiet during hard reset and soft clear.
    if (!rst_ni || !dmactive_i) begin
      master_req_o = 1'b0;
      gnt_o        = '0;
      r_valid_o    = '0;
      r_err_o      = '0;
      r_rdata_o    = master_r_rdata_i;
    end
    if (!dmactive_i) begin
      state_d = Idle;
      owner_d = '0;
      rr_d    = '0;
      cnt_d   = '0;
    end
  end

  // Master payload follows the selected requester only while a request is presented.
  always_comb begin
    master_add_o   = '0;
    master_we_o    = 1'b0;
    master_wdata_o = '0;
    master_be_o    = '0;
    if (master_req_o) begin
      master_add_o   = add_i[sel];
      master_we_o    = we_i[sel];
      master_wdata_o = wdata_i[sel];
      master_be_o    = be_i[sel];
    end
  end

  assign busy_o = (state_q != Idle);

endmodule
